// File: rtl/dense_sequencer_pkg.sv
// dense_sequencer_pkg: shared state encodings, rail constants, default widths and an address-width helper
package dense_sequencer_pkg;
  localparam logic [2:0] DSEQ_IDLE    = 3'd0;
  localparam logic [2:0] DSEQ_WLOAD   = 3'd1;
  localparam logic [2:0] DSEQ_XDATA   = 3'd2;
  localparam logic [2:0] DSEQ_XNULL   = 3'd3;
  localparam logic [2:0] DSEQ_RESWAIT = 3'd4;
  localparam logic [2:0] DSEQ_RESOUT  = 3'd5;
  localparam logic [2:0] DSEQ_RESNULL = 3'd6;
  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;
  localparam int BIT_DATA_DEF    = 8;
  localparam int DENSE_KSIZE_DEF = 10;
  localparam int BIT_SOFTMAX_DEF = 16;
  localparam int BIT_O_DEF       = 4;
  // Counter width that stays at least one bit for degenerate sizes
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dense_sequencer_sync_ff.sv
// dense_sequencer_sync_ff: SYNC-deep flop synchroniser for async acks and completion flags
module dense_sequencer_sync_ff #(
  parameter int W    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s_q [SYNC];
  // Shift the asynchronous input through SYNC flop stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) s_q[i] <= '0;
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < SYNC; i++) s_q[i] <= s_q[i-1];
    end
  end
  assign q_o = s_q[SYNC-1];
endmodule

// File: rtl/dense_sequencer.sv
// dense_sequencer: clocked weight-load / dual-rail activation / argmax-capture controller for layer_dense (optional watchdog: DENSE_TIMEOUT_EN)
module dense_sequencer
  import dense_sequencer_pkg::*;
#(
  parameter int BIT_DATA    = BIT_DATA_DEF,
  parameter int KSIZE       = DENSE_KSIZE_DEF,
  parameter int SIZE        = 128,
  parameter int BIT_SOFTMAX = BIT_SOFTMAX_DEF,
  parameter int BIT_O       = BIT_O_DEF,
  parameter int SYNC        = 2,
  parameter int TIMEOUT     = 1023,
  localparam int AW0 = cw(KSIZE),
  localparam int AW1 = cw(SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      wload_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [BIT_DATA*KSIZE-1:0] w_data_i,
  input  logic                      x_valid_i,
  output logic                      x_ready_o,
  input  logic [BIT_DATA-1:0]       x_data_i,
  output logic                      load_o,
  output logic [AW0-1:0]            addr0_o,
  output logic [AW1-1:0]            addr1_o,
  output logic [BIT_DATA*KSIZE-1:0] wt_o,
  output logic [BIT_DATA*KSIZE-1:0] wf_o,
  output logic [BIT_DATA-1:0]       xt_o,
  output logic [BIT_DATA-1:0]       xf_o,
  input  logic                      ack_prev_i,
  output logic                      ack_nxt_o,
  input  logic [BIT_SOFTMAX-1:0]    zt_i,
  input  logic [BIT_SOFTMAX-1:0]    zf_i,
  input  logic [BIT_O-1:0]          idx_t_i,
  input  logic [BIT_O-1:0]          idx_f_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [BIT_SOFTMAX-1:0]    res_z_o,
  output logic [BIT_O-1:0]          res_idx_o,
  output logic                      busy_o,
  output logic                      error_o
);
  logic [2:0]             state_q, state_d;
  logic [AW0-1:0]         addr0_q, addr0_d;
  logic [AW1-1:0]         addr1_q, addr1_d;
  logic [AW1-1:0]         xcnt_q, xcnt_d;
  logic                   tok_q, tok_d;
  logic [BIT_DATA-1:0]    xt_q, xt_d, xf_q, xf_d;
  logic                   ack_nxt_q, ack_nxt_d;
  logic [BIT_SOFTMAX-1:0] res_z_q, res_z_d;
  logic [BIT_O-1:0]       res_idx_q, res_idx_d;
  logic                   ack_s, comp_prev_q, null_prev_q, comp_ok, null_ok, timeout;
  logic [1:0]             flags_s;
  logic                   last0, last1;
  dense_sequencer_sync_ff #(.W(1), .SYNC(SYNC)) u_ack_sync (
    .clk(clk), .rst_n(rst_n), .d_i(ack_prev_i), .q_o(ack_s)
  );
  // Completion means every dual-rail pair has exactly one rail high; null means every rail is low
  dense_sequencer_sync_ff #(.W(2), .SYNC(SYNC)) u_flag_sync (
    .clk(clk), .rst_n(rst_n),
    .d_i({&(zt_i ^ zf_i) & &(idx_t_i ^ idx_f_i), ~|{zt_i | zf_i, idx_t_i | idx_f_i}}),
    .q_o(flags_s)
  );
  assign comp_ok = flags_s[1] & comp_prev_q;
  assign null_ok = flags_s[0] & null_prev_q;
  assign last0   = addr0_q == AW0'(KSIZE - 1);
  assign last1   = addr1_q == AW1'(SIZE - 1);
`ifdef DENSE_TIMEOUT_EN
  localparam int WW = cw(TIMEOUT + 1);
  logic [WW-1:0] wdog_q;
  logic          error_q, watched;
  assign watched = (state_q == DSEQ_XDATA) | (state_q == DSEQ_XNULL) |
                   (state_q == DSEQ_RESWAIT) | (state_q == DSEQ_RESNULL);
  assign timeout = watched & (wdog_q == WW'(TIMEOUT - 1));
  // Watchdog counts stalled cycles in the async-wait states and latches a sticky error on expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      error_q <= OFF;
    end else begin
      wdog_q  <= (watched && state_d == state_q && !timeout) ? wdog_q + 1'b1 : '0;
      error_q <= error_q | timeout;
    end
  end
  assign error_o = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout = OFF;
  assign error_o = OFF;
`endif
  // Next-state logic for the load / four-phase token / result-capture sequence
  always_comb begin
    state_d   = state_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    xcnt_d    = xcnt_q;
    tok_d     = tok_q;
    xt_d      = xt_q;
    xf_d      = xf_q;
    ack_nxt_d = ack_nxt_q;
    res_z_d   = res_z_q;
    res_idx_d = res_idx_q;
    case (state_q)
      DSEQ_IDLE: begin
        ack_nxt_d = ON;
        state_d   = wload_i ? DSEQ_WLOAD : start_i ? DSEQ_XDATA : DSEQ_IDLE;
      end
      DSEQ_WLOAD: if (w_valid_i) begin
        addr0_d = last0 ? '0 : addr0_q + 1'b1;
        addr1_d = last0 ? (last1 ? '0 : addr1_q + 1'b1) : addr1_q;
        state_d = (last0 && last1) ? DSEQ_IDLE : DSEQ_WLOAD;
      end
      DSEQ_XDATA: begin
        if (!tok_q && x_valid_i) begin
          tok_d = ON;
          xt_d  = x_data_i;
          xf_d  = ~x_data_i;
        end else if (tok_q && ack_s) begin
          tok_d   = OFF;
          xt_d    = '0;
          xf_d    = '0;
          state_d = DSEQ_XNULL;
        end
      end
      DSEQ_XNULL: if (!ack_s) begin
        xcnt_d  = (xcnt_q == AW1'(SIZE - 1)) ? '0 : xcnt_q + 1'b1;
        state_d = (xcnt_q == AW1'(SIZE - 1)) ? DSEQ_RESWAIT : DSEQ_XDATA;
      end
      DSEQ_RESWAIT: if (comp_ok) begin
        res_z_d   = zt_i;
        res_idx_d = idx_t_i;
        state_d   = DSEQ_RESOUT;
      end
      DSEQ_RESOUT: if (res_ready_i) begin
        ack_nxt_d = OFF;
        state_d   = DSEQ_RESNULL;
      end
      DSEQ_RESNULL: if (null_ok) begin
        ack_nxt_d = ON;
        state_d   = DSEQ_IDLE;
      end
      default: state_d = DSEQ_IDLE;
    endcase
    if (timeout) begin
      state_d   = DSEQ_IDLE;
      tok_d     = OFF;
      xt_d      = '0;
      xf_d      = '0;
      xcnt_d    = '0;
      ack_nxt_d = OFF;
    end
  end
  // State registers; reset returns the layer interface to null with ack_nxt high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DSEQ_IDLE;
      addr0_q     <= '0;
      addr1_q     <= '0;
      xcnt_q      <= '0;
      tok_q       <= OFF;
      xt_q        <= '0;
      xf_q        <= '0;
      ack_nxt_q   <= ON;
      res_z_q     <= '0;
      res_idx_q   <= '0;
      comp_prev_q <= OFF;
      null_prev_q <= OFF;
    end else begin
      state_q     <= state_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      xcnt_q      <= xcnt_d;
      tok_q       <= tok_d;
      xt_q        <= xt_d;
      xf_q        <= xf_d;
      ack_nxt_q   <= ack_nxt_d;
      res_z_q     <= res_z_d;
      res_idx_q   <= res_idx_d;
      comp_prev_q <= flags_s[1];
      null_prev_q <= flags_s[0];
    end
  end
  assign w_ready_o   = state_q == DSEQ_WLOAD;
  assign load_o      = w_ready_o & w_valid_i;
  assign wt_o        = w_ready_o ? w_data_i : '0;
  assign wf_o        = w_ready_o ? ~w_data_i : '0;
  assign addr0_o     = addr0_q;
  assign addr1_o     = addr1_q;
  assign x_ready_o   = (state_q == DSEQ_XDATA) & ~tok_q;
  assign xt_o        = xt_q;
  assign xf_o        = xf_q;
  assign ack_nxt_o   = ack_nxt_q;
  assign res_valid_o = state_q == DSEQ_RESOUT;
  assign res_z_o     = res_z_q;
  assign res_idx_o   = res_idx_q;
  assign busy_o      = state_q != DSEQ_IDLE;
endmodule
